// File: rtl/param_main_store.sv
// Parametrised single-port word store with req/ack handshake, programmable
// wait states, out-of-range detection and a one-word-per-cycle clear sweep.
module param_main_store #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic              clr_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_CLEAR
    } state_t;

    // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]        WS_L     = 4'(WAIT_STATES);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                clr_done_q, clr_done_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic                in_range;

    assign in_range = ({1'b0, addr_q} < DEPTH_L);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        clr_done_d = 1'b0;
        mem_d      = mem_q;

        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    idx_d   = '0;
                    state_d = S_CLEAR;
                end else if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = WS_L;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ack_d   = 1'b1;
                    err_d   = !in_range;
                    state_d = S_IDLE;
                    if (we_q) begin
                        if (in_range) begin
                            mem_d[addr_q] = wdata_q;
                        end
                    end else begin
                        rdata_d = in_range ? mem_q[addr_q] : '0;
                    end
                end
            end
            S_CLEAR: begin
                mem_d[idx_q] = '0;
                if (idx_q == LAST_IDX) begin
                    clr_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            idx_q      <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            clr_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            idx_q      <= idx_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            clr_done_q <= clr_done_d;
            mem_q      <= mem_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign rdata    = rdata_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign clr_done = clr_done_q;

endmodule
